// File: rtl/cpu_pkg.sv
// Shared definitions for the register-bank port arbiter slice.
//   DEF_ADDR_W / DEF_DATA_W : default register address / data widths
//   arb_state_e             : arbiter FSM states (IDLE, CLEAR)
//   REQ_R0 / REQ_R1         : requester indices (operand fetch / writeback)
package cpu_pkg;

  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_e;

  localparam int REQ_R0 = 0;
  localparam int REQ_R1 = 1;

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Requester-side handshake bundle for one register-bank requester.
//   req    : access request, held with we/addr/wdata until gnt
//   we     : 1 = write, 0 = read
//   addr   : register address
//   wdata  : write data
//   gnt    : one-cycle grant pulse, same cycle the bank sees the access
//   rvalid : read data valid, one cycle after a read grant
// Modports: master = requester, slave = arbiter.
interface regfile_port_arbiter_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   en       : grants allowed this cycle
//   req[1:0] : request vector
//   gnt[1:0] : one-hot (or zero) grant vector, combinational
// The pointer holds the index of the last granted requester; on a tie the
// other requester wins. It resets to REQ_R1 so REQ_R0 wins the first tie.
module rr_arb2
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = (ptr == 1'(REQ_R1)) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'(REQ_R1);
    end else if (gnt[REQ_R0]) begin
      ptr <= 1'(REQ_R0);
    end else if (gnt[REQ_R1]) begin
      ptr <= 1'(REQ_R1);
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares a single-port register bank between operand fetch (r0) and
// writeback (r1), one access per cycle, and runs a software clear sweep
// that writes zero to every register.
//   clk, rst   : clock, asynchronous active-high reset
//   clr_req    : start a clear sweep (sampled in IDLE)
//   clr_busy   : sweep in progress
//   r0, r1     : requester handshake bundles (slave side)
//   rdata      : shared read data, qualified by r0.rvalid / r1.rvalid
//   rf_wr_en   : bank write enable
//   rf_addr    : bank address
//   rf_wdata   : bank write data
//   rf_rdata   : bank read data, registered, valid one cycle after address
module regfile_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = 1 << ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_req,
  output logic                  clr_busy,
  regfile_port_arbiter_if.slave r0,
  regfile_port_arbiter_if.slave r1,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rf_wr_en,
  output logic [ADDR_W-1:0]     rf_addr,
  output logic [DATA_W-1:0]     rf_wdata,
  input  logic [DATA_W-1:0]     rf_rdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  arb_state_e        state;
  logic [ADDR_W-1:0] sweep_cnt;
  logic              arb_en;
  logic [1:0]        req_vec;
  logic [1:0]        gnt_vec;
  logic [1:0]        rd_vld_p1;

  // Clear takes precedence over any pending request in the cycle it starts.
  assign arb_en  = !rst && (state == IDLE) && !clr_req;
  assign req_vec = {r1.req, r0.req};

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (arb_en),
    .req (req_vec),
    .gnt (gnt_vec)
  );

  assign r0.gnt = gnt_vec[REQ_R0];
  assign r1.gnt = gnt_vec[REQ_R1];

  // Stage 0: bank access issued in the grant / sweep cycle
  always_comb begin
    rf_wr_en = 1'b0;
    rf_addr  = '0;
    rf_wdata = '0;
    if (!rst) begin
      if (state == CLEAR) begin
        rf_wr_en = 1'b1;
        rf_addr  = sweep_cnt;
      end else if (gnt_vec[REQ_R0]) begin
        rf_wr_en = r0.we;
        rf_addr  = r0.addr;
        rf_wdata = r0.wdata;
      end else if (gnt_vec[REQ_R1]) begin
        rf_wr_en = r1.we;
        rf_addr  = r1.addr;
        rf_wdata = r1.wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      clr_busy  <= 1'b0;
      sweep_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state     <= CLEAR;
            clr_busy  <= 1'b1;
            sweep_cnt <= '0;
          end
        end
        CLEAR: begin
          if (sweep_cnt == LAST_ADDR) begin
            state     <= IDLE;
            clr_busy  <= 1'b0;
            sweep_cnt <= '0;
          end else begin
            sweep_cnt <= sweep_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          clr_busy  <= 1'b0;
          sweep_cnt <= '0;
        end
      endcase
    end
  end

  // Stage 1: bank read data returns, valid flagged for the read's owner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_p1 <= 2'b00;
    end else begin
      rd_vld_p1[REQ_R0] <= gnt_vec[REQ_R0] && !r0.we;
      rd_vld_p1[REQ_R1] <= gnt_vec[REQ_R1] && !r1.we;
    end
  end

  assign r0.rvalid = rd_vld_p1[REQ_R0];
  assign r1.rvalid = rd_vld_p1[REQ_R1];
  assign rdata     = rf_rdata;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
module tb_regfile_port_arbiter;

  localparam int AW = 3;
  localparam int DW = 4;
  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr_req;
  logic          clr_busy;
  logic [DW-1:0] rdata;
  logic          rf_wr_en;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rf_rdata;

  regfile_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) r0_if ();
  regfile_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) r1_if ();

  regfile_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .r0       (r0_if),
    .r1       (r1_if),
    .rdata    (rdata),
    .rf_wr_en (rf_wr_en),
    .rf_addr  (rf_addr),
    .rf_wdata (rf_wdata),
    .rf_rdata (rf_rdata)
  );

  always #5 clk = ~clk;

  // Register bank: synchronous write, registered read of the presented address.
  logic [DW-1:0] bank [NR];
  always @(posedge clk) begin
    if (rf_wr_en) bank[rf_addr] <= rf_wdata;
    rf_rdata <= bank[rf_addr];
  end

  // Reference model state: what the register file should contain and
  // which requester is owed a turn, in specification terms.
  int refmem [NR];
  bit m_clear;
  int m_idx;
  int m_last;
  bit pend_rv0, pend_rv1;
  int pend_rd;
  bit saw_gnt0, saw_gnt1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic set_req(input int i, input bit r, input bit we, input int a, input int d);
    if (i == 0) begin
      r0_if.req = r; r0_if.we = we; r0_if.addr = AW'(a); r0_if.wdata = DW'(d);
    end else begin
      r1_if.req = r; r1_if.we = we; r1_if.addr = AW'(a); r1_if.wdata = DW'(d);
    end
  endtask

  // One clock cycle: predict and check outputs before the edge, advance
  // the model, then return 1 time unit after the edge for new stimulus.
  task automatic step();
    int g;
    bit e_wr, e_busy, e_rv0, e_rv1, n_rv0, n_rv1, gwe;
    int e_addr, e_data, e_rd, n_rd, ga, gd;
    @(negedge clk);
    g = -1; e_wr = 0; e_addr = 0; e_data = 0; e_busy = 0;
    n_rv0 = 0; n_rv1 = 0; n_rd = 0;
    e_rv0 = pend_rv0; e_rv1 = pend_rv1; e_rd = pend_rd;
    if (rst) begin
      e_rv0 = 0; e_rv1 = 0;
      m_clear = 0; m_idx = 0; m_last = 1;
    end else if (m_clear) begin
      e_wr = 1; e_addr = m_idx; e_busy = 1;
      refmem[m_idx] = 0;
      m_idx++;
      if (m_idx == NR) begin m_clear = 0; m_idx = 0; end
    end else if (clr_req) begin
      m_clear = 1; m_idx = 0;
    end else begin
      if (r0_if.req && r1_if.req) g = (m_last == 0) ? 1 : 0;
      else if (r0_if.req) g = 0;
      else if (r1_if.req) g = 1;
      if (g >= 0) begin
        gwe = (g == 0) ? r0_if.we : r1_if.we;
        ga  = (g == 0) ? int'(r0_if.addr)  : int'(r1_if.addr);
        gd  = (g == 0) ? int'(r0_if.wdata) : int'(r1_if.wdata);
        e_wr = gwe; e_addr = ga; e_data = gd;
        m_last = g;
        if (gwe) refmem[ga] = gd;
        else begin
          if (g == 0) n_rv0 = 1; else n_rv1 = 1;
          n_rd = refmem[ga];
        end
      end
    end
    chk("r0_gnt",    32'(r0_if.gnt), 32'(g == 0));
    chk("r1_gnt",    32'(r1_if.gnt), 32'(g == 1));
    chk("rf_wr_en",  32'(rf_wr_en),  32'(e_wr));
    chk("rf_addr",   32'(rf_addr),   32'(e_addr));
    chk("rf_wdata",  32'(rf_wdata),  32'(e_data));
    chk("clr_busy",  32'(clr_busy),  32'(e_busy));
    chk("r0_rvalid", 32'(r0_if.rvalid), 32'(e_rv0));
    chk("r1_rvalid", 32'(r1_if.rvalid), 32'(e_rv1));
    if (e_rv0 || e_rv1) chk("rdata", 32'(rdata), 32'(e_rd));
    saw_gnt0 = r0_if.gnt;
    saw_gnt1 = r1_if.gnt;
    pend_rv0 = n_rv0; pend_rv1 = n_rv1; pend_rd = n_rd;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand();
    if (!r0_if.req || saw_gnt0) begin
      if ($urandom_range(0, 3) != 0) set_req(0, 1, 1'($urandom_range(0, 1)), $urandom_range(0, NR-1), $urandom_range(0, 15));
      else set_req(0, 0, 0, 0, 0);
    end
    if (!r1_if.req || saw_gnt1) begin
      if ($urandom_range(0, 3) != 0) set_req(1, 1, 1'($urandom_range(0, 1)), $urandom_range(0, NR-1), $urandom_range(0, 15));
      else set_req(1, 0, 0, 0, 0);
    end
    clr_req = ($urandom_range(0, 49) == 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NR; i++) refmem[i] = 0;
    m_clear = 0; m_idx = 0; m_last = 1;
    pend_rv0 = 0; pend_rv1 = 0; pend_rd = 0;
    saw_gnt0 = 0; saw_gnt1 = 0;
    rst = 1'b1; clr_req = 1'b0;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    #1;

    // Reset, then start from a fully cleared bank so every read is known.
    repeat (3) step();
    rst = 1'b0;
    clr_req = 1'b1; step(); clr_req = 1'b0;
    repeat (NR) step();

    // r0 writes 3=A, r1 reads it back.
    set_req(0, 1, 1, 3, 4'hA); step();
    set_req(0, 0, 0, 0, 0); set_req(1, 1, 0, 3, 0); step();
    set_req(1, 0, 0, 0, 0); step();

    // Both hold reads: alternating grants.
    set_req(0, 1, 0, 1, 0); set_req(1, 1, 0, 2, 0);
    repeat (6) step();
    set_req(0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0); step();

    // Preload 0xF, then clear while r0 waits to read addr 5.
    for (int a = 0; a < NR; a++) begin set_req(1, 1, 1, a, 4'hF); step(); end
    set_req(1, 0, 0, 0, 0);
    set_req(0, 1, 0, 5, 0); clr_req = 1'b1; step(); clr_req = 1'b0;
    repeat (NR + 1) step();
    set_req(0, 0, 0, 0, 0); step();

    // Reset while the sweep presents address 4.
    clr_req = 1'b1; step(); clr_req = 1'b0;
    repeat (4) step();
    set_req(0, 1, 1, 0, 1); set_req(1, 1, 1, 1, 2);
    rst = 1'b1;
    #1;
    chk("rst_clr_busy", 32'(clr_busy), 32'd0);
    chk("rst_wr_en",    32'(rf_wr_en), 32'd0);
    chk("rst_r0_gnt",   32'(r0_if.gnt), 32'd0);
    chk("rst_r1_gnt",   32'(r1_if.gnt), 32'd0);
    repeat (2) step();
    rst = 1'b0;
    step(); set_req(0, 0, 0, 0, 0);
    step(); set_req(1, 0, 0, 0, 0);
    step();

    // r1 alone: write 7=5 then read it back-to-back.
    set_req(1, 1, 1, 7, 4'h5); step();
    set_req(1, 1, 0, 7, 0); step();
    set_req(1, 0, 0, 0, 0); step();

    // clr_req held for 20 cycles with r0 waiting.
    set_req(0, 1, 0, 7, 0); clr_req = 1'b1;
    repeat (20) step();
    clr_req = 1'b0;
    repeat (8) step();
    set_req(0, 0, 0, 0, 0); step();

    // Randomized traffic with occasional clear pulses.
    for (int c = 0; c < 500; c++) begin
      drive_rand();
      step();
    end
    clr_req = 1'b0;
    set_req(0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0);
    repeat (12) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
Shares the single-port CPU register bank between two requesters: r0 is operand fetch and r1 is writeback. It issues at most one bank access per cycle, using round-robin arbitration with a req/gnt handshake. It also runs a software clear sweep that zeroes every register without a system reset. It sits between the decode/writeback logic and the register bank.

Parameters:
ADDR_W, 3, register address width
DATA_W, 4, register data width
NUM_REGS, 1<<ADDR_W, number of registers swept by clear

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
clr_req  in  1  start clear sweep (level sampled in IDLE)
clr_busy  out  1  clear sweep in progress
r0_req  in  1  requester 0 access request
r0_we  in  1  requester 0 write enable (0 = read)
r0_addr  in  ADDR_W  requester 0 register address
r0_wdata  in  DATA_W  requester 0 write data
r0_gnt  out  1  requester 0 grant, one-cycle pulse per access
r0_rvalid  out  1  requester 0 read data valid
r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid  same as r0, for requester 1
rdata  out  DATA_W  read data, shared; qualified by rN_rvalid
rf_wr_en  out  1  bank write enable
rf_addr  out  ADDR_W  bank address
rf_wdata  out  DATA_W  bank write data
rf_rdata  in  DATA_W  bank registered read data, valid 1 cycle after address

Behaviour:
- Reset (async, rst=1): FSM=IDLE, clr_busy=0, sweep counter=0, both rvalid=0, last-grant pointer=1 (so r0 wins the first tie). While rst=1, gnt, rf_wr_en, rf_addr and rf_wdata are all 0.
- FSM states: IDLE and CLEAR.
  - IDLE->CLEAR when clr_req=1.
  - CLEAR->IDLE after the access with sweep counter=NUM_REGS-1.
- Handshake: a requester holds req, we, addr and wdata stable until it sees gnt. gnt is combinational in cycle N, and rf_* carry the granted fields in the same cycle N. The requester may drop req or present a new request in N+1.
- Arbitration (IDLE, clr_req=0):
  - One requester active: it is granted, every cycle if it keeps requesting.
  - Both active: the requester not equal to the pointer is granted.
  - The pointer updates to the granted index on each grant only.
- No grant in IDLE: rf_wr_en=0, rf_addr=0, rf_wdata=0.
- Read latency: a read granted in cycle N gives rN_rvalid=1 in N+1 (registered one-cycle pulse), with rdata=rf_rdata in N+1. Writes never raise rvalid.
- Write-then-read: a write granted in N followed by a read of the same address granted in N+1 returns the new data in N+2.
- clr_req=1 in IDLE at cycle N:
  - Clear takes precedence; no grants are issued in N.
  - clr_busy=1 from N+1 through N+NUM_REGS.
  - Cycles N+1..N+NUM_REGS drive rf_wr_en=1, rf_addr=0..NUM_REGS-1 in order, rf_wdata=0.
  - No grants during CLEAR; requests stay pending.
  - Grants resume in N+NUM_REGS+1. The pointer is unchanged across the clear.
- clr_req during CLEAR is ignored. If clr_req is still high on return to IDLE, a new sweep starts with no grant in that cycle.
- A read granted in N-1 still delivers rvalid in N even if the clear begins in N; rdata is the pre-clear value.
- rst asserted mid-sweep: immediate return to reset state. The sweep is abandoned (partially cleared bank is acceptable), counter=0, and no resume after release.
- Never more than one of r0_gnt, r1_gnt and the sweep write active per cycle; never both rvalid high in one cycle.

Decomposition:
- Shared package cpu_pkg: ADDR_W and DATA_W defaults, the arbiter state enum {IDLE, CLEAR}, and the requester index constants REQ_R0=0 and REQ_R1=1.
- One sub-module, rr_arb2: a two-way round-robin arbiter holding the pointer register. Inputs are req[1:0] and an enable; outputs are a one-hot gnt[1:0]. The parent FSM drives enable=0 in CLEAR or when clr_req=1.

Test Plan:
- Reset, then r0 writes addr 3 = 0xA; next cycle r1 reads addr 3 -> r0_gnt and r1_gnt in consecutive cycles; r1_rvalid=1 with rdata=0xA one cycle after r1_gnt; r0_rvalid stays 0.
- r0 and r1 both hold read requests (addr 1, addr 2) for 6 cycles -> grants r0,r1,r0,r1,r0,r1; rvalid alternates likewise one cycle later with the correct data.
- Preload all regs with 0xF, then pulse clr_req while r0_req is held for a read of addr 5:
  - no r0_gnt for 9 cycles;
  - rf_wr_en=1 for 8 cycles with addr 0..7 and data 0; clr_busy high for those 8 cycles;
  - r0_gnt follows, and the read returns 0x0.
- Assert rst while the sweep is at addr 4 -> clr_busy, rf_wr_en and gnt drop to 0 immediately. After release, with both requesting, r0 wins first.
- Only r1 requests: write addr 7 = 0x5, then read addr 7 back-to-back -> grants in consecutive cycles; r1_rvalid with rdata=0x5 two cycles after the write grant.
- clr_req held high for 20 cycles -> back-to-back sweeps with exactly one IDLE cycle between them and no grants issued.
